bird_physics: RTL and testbench
===============================

Name: bird_physics

Overview:
Per-frame vertical motion engine for the player bird. Integrates gravity and flap impulses once per video frame and runs the play/fall/dead life-cycle. Its output `bird_reg` is the 32-bit bird-top-edge word consumed directly by the bird display stage. Collision input comes from the pixel-overlap logic (bird-inside and pipe-inside).

Parameters:
SCREEN_HEIGHT, 480, visible lines
BIRD_HEIGHT, 35, bird sprite height in pixels
START_Y, 200, bird top edge in IDLE and after restart
FLOOR_Y, 445, lowest legal top edge (SCREEN_HEIGHT - BIRD_HEIGHT)
GRAVITY, 1, downward velocity added per frame (px/frame)
FLAP_VELOCITY, 8, upward speed set by a flap (px/frame)
MAX_FALL_SPEED, 10, downward velocity clamp (px/frame)

Ports:
clk  input  1  system clock
reset  input  1  synchronous, active-high reset
frame_tick  input  1  one-cycle pulse per frame (start of vertical blank)
flap  input  1  player button, level, already synchronised
collision  input  1  level; bird overlaps a pipe this cycle
bird_reg  output  32  {23'b0, bird_y}; top edge of bird, for the display stage
bird_velocity  output  8  signed velocity, positive = downward
state  output  2  0 IDLE, 1 FLYING, 2 FALLING, 3 DEAD
game_over  output  1  high while state == DEAD

Behaviour:
- Reset (synchronous, active-high): state=IDLE; bird_y=START_Y; velocity=0; flap_pending=0; game_over=0.
- Reset also sets flap_prev=1, so a button held through reset does not create an edge.
- Flap edge = flap & ~flap_prev, evaluated every cycle.
  - The edge sets flap_pending.
  - Every frame_tick clears flap_pending.
  - An edge on the same cycle as frame_tick counts for that tick.
  - Holding the button yields exactly one flap.
- Physics is applied only on frame_tick cycles.
- bird_reg, bird_velocity and state update on the clock edge ending the tick cycle (1-cycle latency).
- They are stable for the rest of the frame.
- Arithmetic:
  - Velocity is 8-bit signed.
  - Position sum is computed in 11-bit signed: y_sum = bird_y + v_next.
  - v_next: if a flap applies, -FLAP_VELOCITY; else min(v + GRAVITY, MAX_FALL_SPEED).
  - If y_sum < 0: bird_y=0 and v=0 (ceiling; no death).
  - If y_sum >= FLOOR_Y: bird_y=FLOOR_Y and v=0 (floor).
  - Otherwise bird_y = y_sum[8:0].
- IDLE:
  - Position and velocity frozen.
  - A tick with a flap pending or on edge -> FLYING, applying the flap physics that same tick (y becomes START_Y-8).
  - collision is ignored.
- FLYING:
  - Normal physics on each tick.
  - Floor reached -> DEAD.
  - collision high on any cycle -> FALLING.
  - collision and frame_tick on the same cycle: collision wins; that tick applies gravity-only physics and ignores the flap.
- FALLING:
  - Flaps are ignored and flap_pending is discarded.
  - Gravity-only physics each tick.
  - Floor reached -> DEAD.
  - Further collision input is ignored.
- DEAD:
  - Frozen at FLOOR_Y, v=0, game_over=1.
  - A flap edge (any cycle) -> IDLE on the next clock, with bird_y=START_Y, v=0, flap_pending=0.
  - The restart edge does not also start flight.
- Reset in any state overrides all other inputs on that cycle.
- frame_tick held for more than 1 cycle is illegal; each cycle it is high is treated as a separate tick.

Decomposition:
- Shared constants file `game_constants`:
  - state encodings (IDLE/FLYING/FALLING/DEAD);
  - screen dimensions;
  - BIRD_HEIGHT and BIRD_LEFT_EDGE;
  - the bird_reg packing (top edge in bits [8:0]).
- These constants are shared with the display and collision stages.
- One sub-module: `flap_latch` (edge detect + pending flag, clear-on-tick, clear input for FALLING/DEAD).
- Physics datapath and FSM stay in bird_physics.

Test Plan:
1. Reset, then 5 frame_ticks with flap=0 -> bird_reg=200, state=IDLE, velocity=0 throughout.
2. Flap pulse, then a tick -> state=FLYING, v=-8, y=192; next tick v=-7, y=185; third tick v=-6, y=179.
3. Flap held high for 3 ticks -> only the first tick flaps (v=-8, -7, -6); with flap held through reset, no edge and state stays IDLE.
4. Bird at y=5, v=-8 when a flap tick arrives -> y=0, v=0, still FLYING.
5. Falling from v=0, y=200:
   - ticks give v=1,2,3 and y=201,203,206;
   - after 10 ticks v stays 10;
   - y clamps to 445 and state becomes DEAD with game_over=1.
6. Collision asserted together with frame_tick and a flap edge while FLYING at y=300, v=-3:
   - gravity-only physics that tick: state=FALLING, v=-2, y=298;
   - later flaps have no effect; the bird reaches 445 and enters DEAD;
   - a flap edge then gives IDLE, y=200, v=0, game_over=0.

Source files
------------

// File: rtl/game_constants.sv
// Constants shared by the bird physics, display and collision stages:
// life-cycle encodings, screen geometry and the bird_reg packing.
package game_constants;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_FLYING  = 2'd1,
        ST_FALLING = 2'd2,
        ST_DEAD    = 2'd3
    } bird_state_e;

    localparam int BIRD_Y_W = 9;

    localparam logic [9:0] SCREEN_WIDTH   = 10'd640;
    localparam logic [9:0] SCREEN_HEIGHT  = 10'd480;
    localparam logic [5:0] BIRD_HEIGHT    = 6'd35;
    localparam logic [9:0] BIRD_LEFT_EDGE = 10'd120;

    localparam logic [BIRD_Y_W-1:0] START_Y = 9'd200;
    localparam logic [BIRD_Y_W-1:0] FLOOR_Y = 9'd445;

    localparam logic signed [7:0] GRAVITY        = 8'sd1;
    localparam logic signed [7:0] FLAP_VELOCITY  = 8'sd8;
    localparam logic signed [7:0] MAX_FALL_SPEED = 8'sd10;

    // Top edge lives in bits [8:0] of the display word.
    function automatic logic [31:0] pack_bird_reg(input logic [BIRD_Y_W-1:0] y);
        return {23'd0, y};
    endfunction

endpackage

// File: rtl/bird_physics_flap_latch.sv
// Flap button edge detector with a pending flag that survives until the
// next frame tick, plus a discard input used while falling or dead.
module flap_latch (
    input  logic clk,
    input  logic reset,
    input  logic flap,
    input  logic frame_tick,
    input  logic clear,
    output logic flap_edge,
    output logic flap_apply
);

    logic flap_prev_r;
    logic flap_pending_r;
    logic flap_edge_s;

    assign flap_edge_s = flap & ~flap_prev_r;
    assign flap_edge   = flap_edge_s;
    // An edge arriving on the tick cycle itself counts for that tick.
    assign flap_apply  = flap_pending_r | flap_edge_s;

    // Previous button level; preset high so a held button is not an edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            flap_prev_r <= 1'b1;
        end else begin
            flap_prev_r <= flap;
        end
    end

    // Pending flag: set by an edge, consumed by a tick or discarded by clear.
    always_ff @(posedge clk) begin
        if (reset) begin
            flap_pending_r <= 1'b0;
        end else if (clear || frame_tick) begin
            flap_pending_r <= 1'b0;
        end else if (flap_edge_s) begin
            flap_pending_r <= 1'b1;
        end else begin
            flap_pending_r <= flap_pending_r;
        end
    end

endmodule

// File: rtl/bird_physics.sv
// Per-frame vertical motion engine for the player bird: gravity/flap
// integration with ceiling and floor clamps, and the play/fall/dead FSM.
module bird_physics
    import game_constants::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        frame_tick,
    input  logic        flap,
    input  logic        collision,
    output logic [31:0] bird_reg,
    output logic [7:0]  bird_velocity,
    output logic [1:0]  state,
    output logic        game_over
);

    bird_state_e              state_r, state_next_s;
    logic [BIRD_Y_W-1:0]      bird_y_r, y_next_s;
    logic signed [7:0]        vel_r, v_next_s;
    logic                     game_over_r;

    logic                     flap_edge_s;
    logic                     flap_apply_s;
    logic                     flap_clear_s;

    logic                     phys_flap_s;
    logic signed [7:0]        v_grav_s;
    logic signed [7:0]        v_cand_s;
    logic signed [7:0]        v_try_s;
    logic signed [10:0]       y_sum_s;
    logic [BIRD_Y_W-1:0]      phys_y_s;
    logic signed [7:0]        phys_v_s;
    logic                     floor_hit_s;

    flap_latch u_flap_latch (
        .clk        (clk),
        .reset      (reset),
        .flap       (flap),
        .frame_tick (frame_tick),
        .clear      (flap_clear_s),
        .flap_edge  (flap_edge_s),
        .flap_apply (flap_apply_s)
    );

    // Flaps are discarded once the bird has been hit or is dead.
    always_comb begin
        if ((state_r == ST_FALLING) || (state_r == ST_DEAD)) begin
            flap_clear_s = 1'b1;
        end else begin
            flap_clear_s = 1'b0;
        end
    end

    // Whether this tick's physics uses the flap impulse; collision beats flap.
    always_comb begin
        phys_flap_s = 1'b0;
        case (state_r)
            ST_IDLE:   phys_flap_s = 1'b1;
            ST_FLYING: phys_flap_s = flap_apply_s & ~collision;
            default:   phys_flap_s = 1'b0;
        endcase
    end

    // One integration step: velocity update, 11-bit signed position sum, clamps.
    always_comb begin
        v_grav_s = vel_r + GRAVITY;
        if (v_grav_s > MAX_FALL_SPEED) begin
            v_cand_s = MAX_FALL_SPEED;
        end else begin
            v_cand_s = v_grav_s;
        end
        if (phys_flap_s) begin
            v_try_s = -FLAP_VELOCITY;
        end else begin
            v_try_s = v_cand_s;
        end
        y_sum_s = $signed({2'b00, bird_y_r}) + $signed({{3{v_try_s[7]}}, v_try_s});
        if (y_sum_s < 11'sd0) begin
            phys_y_s    = 9'd0;
            phys_v_s    = 8'sd0;
            floor_hit_s = 1'b0;
        end else if (y_sum_s >= $signed({2'b00, FLOOR_Y})) begin
            phys_y_s    = FLOOR_Y;
            phys_v_s    = 8'sd0;
            floor_hit_s = 1'b1;
        end else begin
            phys_y_s    = y_sum_s[8:0];
            phys_v_s    = v_try_s;
            floor_hit_s = 1'b0;
        end
    end

    // Life-cycle next state and the position/velocity to register.
    always_comb begin
        state_next_s = state_r;
        y_next_s     = bird_y_r;
        v_next_s     = vel_r;
        case (state_r)
            ST_IDLE: begin
                if (frame_tick && flap_apply_s) begin
                    state_next_s = ST_FLYING;
                    y_next_s     = phys_y_s;
                    v_next_s     = phys_v_s;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_FLYING: begin
                if (collision) begin
                    state_next_s = ST_FALLING;
                end else begin
                    state_next_s = ST_FLYING;
                end
                if (frame_tick) begin
                    y_next_s = phys_y_s;
                    v_next_s = phys_v_s;
                    if (floor_hit_s) begin
                        state_next_s = ST_DEAD;
                    end else begin
                        state_next_s = state_next_s;
                    end
                end else begin
                    y_next_s = bird_y_r;
                end
            end
            ST_FALLING: begin
                if (frame_tick) begin
                    y_next_s = phys_y_s;
                    v_next_s = phys_v_s;
                    if (floor_hit_s) begin
                        state_next_s = ST_DEAD;
                    end else begin
                        state_next_s = ST_FALLING;
                    end
                end else begin
                    state_next_s = ST_FALLING;
                end
            end
            ST_DEAD: begin
                if (flap_edge_s) begin
                    state_next_s = ST_IDLE;
                    y_next_s     = START_Y;
                    v_next_s     = 8'sd0;
                end else begin
                    state_next_s = ST_DEAD;
                    y_next_s     = FLOOR_Y;
                    v_next_s     = 8'sd0;
                end
            end
            default: begin
                state_next_s = ST_IDLE;
                y_next_s     = START_Y;
                v_next_s     = 8'sd0;
            end
        endcase
    end

    // State, position, velocity and game_over registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r     <= ST_IDLE;
            bird_y_r    <= START_Y;
            vel_r       <= 8'sd0;
            game_over_r <= 1'b0;
        end else begin
            state_r     <= state_next_s;
            bird_y_r    <= y_next_s;
            vel_r       <= v_next_s;
            game_over_r <= (state_next_s == ST_DEAD);
        end
    end

    assign bird_reg      = pack_bird_reg(bird_y_r);
    assign bird_velocity = vel_r;
    assign state         = state_r;
    assign game_over     = game_over_r;

endmodule

// File: tb/tb_bird_physics.sv
// Directed bench for bird_physics: a behavioural model pushes the expected
// registered outputs per cycle, which are popped and checked after the edge.
module tb_bird_physics;

    logic        clk;
    logic        reset;
    logic        frame_tick;
    logic        flap;
    logic        collision;
    logic [31:0] bird_reg;
    logic [7:0]  bird_velocity;
    logic [1:0]  state;
    logic        game_over;

    bird_physics dut (
        .clk           (clk),
        .reset         (reset),
        .frame_tick    (frame_tick),
        .flap          (flap),
        .collision     (collision),
        .bird_reg      (bird_reg),
        .bird_velocity (bird_velocity),
        .state         (state),
        .game_over     (game_over)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int st;
        int y;
        int v;
        int go;
    } exp_t;

    exp_t exp_q[$];

    int tests;
    int fails;

    int m_state;
    int m_y;
    int m_v;
    int m_pending;
    int m_prev;
    int max_v;

    task automatic check(input string name, input logic signed [31:0] got,
                         input logic signed [31:0] want);
        tests++;
        assert (got === want) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", name, got, want);
        end
    endtask

    // Integrate one tick in the model; returns 1 when the floor was reached.
    function automatic int model_phys(input int use_flap);
        int vn;
        int s;
        if (use_flap != 0) vn = -8;
        else vn = (m_v + 1 > 10) ? 10 : m_v + 1;
        s = m_y + vn;
        if (s < 0) begin
            m_y = 0; m_v = 0; return 0;
        end else if (s >= 445) begin
            m_y = 445; m_v = 0; return 1;
        end
        m_y = s; m_v = vn;
        return 0;
    endfunction

    function automatic void model_step(input int t, input int f, input int c, input int r);
        int edge_f;
        int apply;
        int fl;
        edge_f = (f != 0 && m_prev == 0) ? 1 : 0;
        apply  = (m_pending != 0 || edge_f != 0) ? 1 : 0;
        if (r != 0) begin
            m_state = 0; m_y = 200; m_v = 0; m_pending = 0; m_prev = 1;
            return;
        end
        if (m_state >= 2 || t != 0) m_pending = 0;
        else if (edge_f != 0) m_pending = 1;
        m_prev = f;
        case (m_state)
            0: if (t != 0 && apply != 0) begin
                fl = model_phys(1);
                m_state = 1;
            end
            1: begin
                if (c != 0) m_state = 2;
                if (t != 0) begin
                    fl = model_phys((c == 0 && apply != 0) ? 1 : 0);
                    if (fl != 0) m_state = 3;
                end
            end
            2: if (t != 0) begin
                fl = model_phys(0);
                if (fl != 0) m_state = 3;
            end
            default: if (edge_f != 0) begin
                m_state = 0; m_y = 200; m_v = 0;
            end
        endcase
    endfunction

    task automatic cycle(input logic t, input logic f, input logic c, input logic r);
        exp_t e;
        frame_tick = t;
        flap       = f;
        collision  = c;
        reset      = r;
        model_step(int'(t), int'(f), int'(c), int'(r));
        e.st = m_state; e.y = m_y; e.v = m_v; e.go = (m_state == 3) ? 1 : 0;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        check("state", {30'd0, state}, e.st);
        check("bird_reg", bird_reg, e.y);
        check("velocity", $signed(bird_velocity), e.v);
        check("game_over", {31'd0, game_over}, e.go);
        if ($signed(bird_velocity) > max_v) max_v = $signed(bird_velocity);
    endtask

    task automatic press_tick(input logic c);
        cycle(1'b0, 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 1'b1, c, 1'b0);
    endtask

    initial begin
        tests = 0; fails = 0; max_v = -128;
        m_state = 0; m_y = 200; m_v = 0; m_pending = 0; m_prev = 1;
        frame_tick = 1'b0; flap = 1'b0; collision = 1'b0; reset = 1'b1;

        // 1: reset, idle ticks and an ignored collision keep the bird parked
        cycle(1'b0, 1'b0, 1'b0, 1'b1);
        cycle(1'b0, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 5; i++) begin
            cycle(1'b0, 1'b0, 1'b0, 1'b0);
            cycle(1'b1, 1'b0, 1'b0, 1'b0);
        end
        cycle(1'b1, 1'b0, 1'b1, 1'b0);
        check("idle_y", bird_reg, 200);
        check("idle_state", {30'd0, state}, 0);

        // 2: pending flap consumed by a later tick
        cycle(1'b0, 1'b1, 1'b0, 1'b0);
        cycle(1'b0, 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 1'b0, 1'b0, 1'b0);
        check("flap1_y", bird_reg, 192);
        check("flap1_v", $signed(bird_velocity), -8);
        check("flap1_state", {30'd0, state}, 1);
        cycle(1'b1, 1'b0, 1'b0, 1'b0);
        check("flap2_y", bird_reg, 185);
        cycle(1'b0, 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 1'b0, 1'b0, 1'b0);
        check("flap3_y", bird_reg, 179);
        check("flap3_v", $signed(bird_velocity), -6);

        // 3: held button flaps once; held through reset gives no edge
        cycle(1'b0, 1'b1, 1'b0, 1'b0);
        cycle(1'b1, 1'b1, 1'b0, 1'b0);
        check("hold1_v", $signed(bird_velocity), -8);
        cycle(1'b0, 1'b1, 1'b0, 1'b0);
        cycle(1'b1, 1'b1, 1'b0, 1'b0);
        check("hold2_v", $signed(bird_velocity), -7);
        cycle(1'b1, 1'b1, 1'b0, 1'b0);
        check("hold3_v", $signed(bird_velocity), -6);
        cycle(1'b0, 1'b1, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) cycle(1'b1, 1'b1, 1'b0, 1'b0);
        check("rst_hold_state", {30'd0, state}, 0);
        check("rst_hold_y", bird_reg, 200);

        // 4: repeated flaps drive the bird into the ceiling clamp
        for (int i = 0; i < 26; i++) press_tick(1'b0);
        check("ceil_y", bird_reg, 0);
        check("ceil_v", $signed(bird_velocity), 0);
        check("ceil_state", {30'd0, state}, 1);

        // 5: free fall to the floor with the velocity clamp
        for (int i = 0; i < 300 && m_state != 3; i++) cycle(1'b1, 1'b0, 1'b0, 1'b0);
        check("floor_y", bird_reg, 445);
        check("floor_go", {31'd0, game_over}, 1);
        check("max_fall_v", max_v, 10);

        // 6: restart, climb, collide on a flap tick, fall, restart again
        cycle(1'b0, 1'b0, 1'b0, 1'b0);
        cycle(1'b0, 1'b1, 1'b0, 1'b0);
        check("restart_state", {30'd0, state}, 0);
        check("restart_y", bird_reg, 200);
        cycle(1'b1, 1'b1, 1'b0, 1'b0);
        check("restart_no_fly", {30'd0, state}, 0);
        press_tick(1'b0);
        for (int i = 0; i < 5; i++) cycle(1'b1, 1'b0, 1'b0, 1'b0);
        check("pre_hit_v", $signed(bird_velocity), -3);
        check("pre_hit_y", bird_reg, 167);
        press_tick(1'b1);
        check("hit_state", {30'd0, state}, 2);
        check("hit_v", $signed(bird_velocity), -2);
        check("hit_y", bird_reg, 165);
        for (int i = 0; i < 3; i++) press_tick(1'b0);
        check("fall_ignores_flap", {30'd0, state}, 2);
        for (int i = 0; i < 300 && m_state != 3; i++) cycle(1'b1, 1'b0, 1'b1, 1'b0);
        check("fall_dead", {30'd0, state}, 3);
        cycle(1'b0, 1'b0, 1'b0, 1'b0);
        cycle(1'b0, 1'b1, 1'b0, 1'b0);
        check("final_state", {30'd0, state}, 0);
        check("final_go", {31'd0, game_over}, 0);
        check("final_y", bird_reg, 200);
        cycle(1'b0, 1'b0, 1'b0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
